// File: rtl/bp_sacc_io_master.sv
// Host-side IO master: programs accelerator CSRs (PTR, LEN, START), polls STAT, reads RES.
// Optional poll timeout enabled by defining BP_SACC_IO_MASTER_TIMEOUT_EN.
module bp_sacc_io_master #(
   parameter int          paddr_width_p = 40,
   parameter int          data_width_p  = 64,
   parameter logic [63:0] csr_base_p    = 64'h0,
   parameter int          poll_gap_p    = 16,
   parameter int          timeout_p     = 1024
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     start_i,
   input  logic [paddr_width_p-1:0] src_addr_i,
   input  logic [data_width_p-1:0]  len_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     error_o,
   output logic [data_width_p-1:0]  result_o,
   output logic                     io_cmd_v_o,
   input  logic                     io_cmd_ready_i,
   output logic                     io_cmd_w_o,
   output logic [paddr_width_p-1:0] io_cmd_addr_o,
   output logic [2:0]               io_cmd_size_o,
   output logic [data_width_p-1:0]  io_cmd_data_o,
   input  logic                     io_resp_v_i,
   input  logic                     io_resp_w_i,
   input  logic [data_width_p-1:0]  io_resp_data_i,
   output logic                     io_resp_yumi_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_PTR, S_WR_LEN, S_WR_GO, S_GAP, S_POLL, S_RD_RES, S_DONE, S_ERR
   } state_e;

   localparam logic [paddr_width_p-1:0] base_lp  = paddr_width_p'(csr_base_p);
   localparam logic [paddr_width_p-1:0] ptr_lp   = base_lp + paddr_width_p'(8'h00);
   localparam logic [paddr_width_p-1:0] len_lp   = base_lp + paddr_width_p'(8'h08);
   localparam logic [paddr_width_p-1:0] go_lp    = base_lp + paddr_width_p'(8'h10);
   localparam logic [paddr_width_p-1:0] stat_lp  = base_lp + paddr_width_p'(8'h18);
   localparam logic [paddr_width_p-1:0] res_lp   = base_lp + paddr_width_p'(8'h20);
   localparam int                       gap_w_lp = $clog2(poll_gap_p + 1);

   state_e                     state_q, state_d;
   logic                       wait_q, wait_d;
   logic                       cmd_v_q, cmd_v_d, cmd_w_q, cmd_w_d;
   logic [paddr_width_p-1:0]   cmd_addr_q, cmd_addr_d;
   logic [data_width_p-1:0]    cmd_data_q, cmd_data_d;
   logic [data_width_p-1:0]    len_q, len_d, result_q, result_d;
   logic                       busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic [gap_w_lp-1:0]        gap_cnt_q, gap_cnt_d;
`ifdef BP_SACC_IO_MASTER_TIMEOUT_EN
   localparam int              poll_w_lp = $clog2(timeout_p + 1);
   logic [poll_w_lp-1:0]       poll_cnt_q, poll_cnt_d;
`endif

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      cmd_v_d    = cmd_v_q;
      cmd_w_d    = cmd_w_q;
      cmd_addr_d = cmd_addr_q;
      cmd_data_d = cmd_data_q;
      len_d      = len_q;
      result_d   = result_q;
      error_d    = error_q;
      gap_cnt_d  = gap_cnt_q;
`ifdef BP_SACC_IO_MASTER_TIMEOUT_EN
      poll_cnt_d = poll_cnt_q;
`endif
      case (state_q)
         S_IDLE: if (start_i) begin
            result_d = '0;
            error_d  = 1'b0;
`ifdef BP_SACC_IO_MASTER_TIMEOUT_EN
            poll_cnt_d = '0;
`endif
            if (len_i != '0) begin
               state_d    = S_WR_PTR;
               len_d      = len_i;
               cmd_v_d    = 1'b1;
               cmd_w_d    = 1'b1;
               cmd_addr_d = ptr_lp;
               cmd_data_d = data_width_p'(src_addr_i);
            end else begin
               state_d = S_DONE;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == gap_w_lp'(poll_gap_p - 1)) begin
               state_d    = S_POLL;
               cmd_v_d    = 1'b1;
               cmd_w_d    = 1'b0;
               cmd_addr_d = stat_lp;
               cmd_data_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         S_DONE, S_ERR: state_d = S_IDLE;
         default: begin
            // Command states: SEND holds v until ready, WAIT takes the single response.
            if (!wait_q) begin
               if (io_cmd_ready_i) begin
                  cmd_v_d = 1'b0;
                  wait_d  = 1'b1;
               end
            end else if (io_resp_v_i) begin
               wait_d = 1'b0;
               if (io_resp_w_i != cmd_w_q) begin
                  state_d = S_ERR;
               end else begin
                  case (state_q)
                     S_WR_PTR: begin
                        state_d    = S_WR_LEN;
                        cmd_v_d    = 1'b1;
                        cmd_addr_d = len_lp;
                        cmd_data_d = len_q;
                     end
                     S_WR_LEN: begin
                        state_d    = S_WR_GO;
                        cmd_v_d    = 1'b1;
                        cmd_addr_d = go_lp;
                        cmd_data_d = data_width_p'(1);
                     end
                     S_WR_GO: begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                     end
                     S_POLL: begin
                        if (io_resp_data_i[0]) begin
                           state_d    = S_RD_RES;
                           cmd_v_d    = 1'b1;
                           cmd_addr_d = res_lp;
                        end else begin
`ifdef BP_SACC_IO_MASTER_TIMEOUT_EN
                           if (poll_cnt_q == poll_w_lp'(timeout_p - 1)) begin
                              state_d = S_ERR;
                           end else begin
                              poll_cnt_d = poll_cnt_q + 1'b1;
                              state_d    = S_GAP;
                              gap_cnt_d  = '0;
                           end
`else
                           state_d   = S_GAP;
                           gap_cnt_d = '0;
`endif
                        end
                     end
                     S_RD_RES: begin
                        result_d = io_resp_data_i;
                        state_d  = S_DONE;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase
      done_d = (state_d == S_DONE) || (state_d == S_ERR);
      if (state_d == S_ERR) error_d = 1'b1;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         wait_q     <= 1'b0;
         cmd_v_q    <= 1'b0;
         cmd_w_q    <= 1'b0;
         cmd_addr_q <= '0;
         cmd_data_q <= '0;
         len_q      <= '0;
         result_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         gap_cnt_q  <= '0;
`ifdef BP_SACC_IO_MASTER_TIMEOUT_EN
         poll_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         cmd_v_q    <= cmd_v_d;
         cmd_w_q    <= cmd_w_d;
         cmd_addr_q <= cmd_addr_d;
         cmd_data_q <= cmd_data_d;
         len_q      <= len_d;
         result_q   <= result_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         gap_cnt_q  <= gap_cnt_d;
`ifdef BP_SACC_IO_MASTER_TIMEOUT_EN
         poll_cnt_q <= poll_cnt_d;
`endif
      end
   end

   // Responses are always consumed; outside WAIT they are simply discarded.
   assign io_resp_yumi_o = io_resp_v_i & ~reset_i;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign result_o       = result_q;
   assign io_cmd_v_o     = cmd_v_q;
   assign io_cmd_w_o     = cmd_w_q;
   assign io_cmd_addr_o  = cmd_addr_q;
   assign io_cmd_size_o  = 3'd3;
   assign io_cmd_data_o  = cmd_data_q;

endmodule
